// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO pointer logic:
// pointer-width computation and binary-to-Gray conversion.
package fifo_pkg;

    // Widest pointer the helper functions accept; callers cast down to their width.
    localparam int MAX_W = 32;

    // Pointers carry one extra wrap bit beyond the RAM address.
    function automatic int ptr_w(input int depth_size);
        return depth_size + 1;
    endfunction

    // Reflected binary code; callers truncate the result to their pointer width.
    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/fifo_wptr_full_if.sv
// Producer-facing bundle of the FIFO write-side controller.
interface fifo_wptr_full_if #(
    parameter int DEPTH_SIZE = 4
);
    logic                  wr_en;
    logic                  wr_push;
    logic [DEPTH_SIZE-1:0] wr_addr;
    logic                  full;
    logic                  almost_full;
    logic [DEPTH_SIZE:0]   wr_level;
    logic                  wr_overflow;

    // Producer side: requests writes, observes RAM strobe and status.
    modport master (
        output wr_en,
        input  wr_push, wr_addr, full, almost_full, wr_level, wr_overflow
    );

    // Controller side: accepts requests, drives RAM strobe and status.
    modport slave (
        input  wr_en,
        output wr_push, wr_addr, full, almost_full, wr_level, wr_overflow
    );
endinterface

// File: rtl/fifo_wptr_full_gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR
// of all Gray bits at and above its position.
module gray2bin #(
    parameter int W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    // Prefix XOR from the MSB down to each bit position.
    always_comb begin
        // NOTE: default assignment first so every path assigns bin and no latch is inferred.
        bin = '0;
        for (int i = 0; i < W; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and status controller of the asynchronous FIFO.
// Holds binary/Gray write pointers, synchronises the read Gray pointer
// through two flops and produces registered full, almost_full, level
// and overflow status. Status is pessimistic: reads become visible only
// after the synchroniser delay, so occupancy is never under-reported.
module fifo_wptr_full
    import fifo_pkg::*;
#(
    parameter int DEPTH_SIZE = 4,
    parameter int AF_THRESH  = 12
) (
    input  logic                wr_clk,
    input  logic                wr_rst,
    input  logic [DEPTH_SIZE:0] rd_ptr_gray,
    output logic [DEPTH_SIZE:0] wr_ptr_gray,
    fifo_wptr_full_if.slave     wr_if
);

    localparam int PTR_W = ptr_w(DEPTH_SIZE);
    localparam logic [PTR_W-1:0] AF_LVL = PTR_W'(AF_THRESH);

    logic [PTR_W-1:0] wr_bin;
    logic [PTR_W-1:0] wr_bin_next;
    logic [PTR_W-1:0] wr_gray_next;
    logic [PTR_W-1:0] rd_bin_sync;
    logic [PTR_W-1:0] level_next;
    logic [PTR_W-1:0] full_pattern;
    logic             push;
    logic             full_next;
    logic             af_next;

    // Two-flop synchroniser for the read pointer; placement tools keep these adjacent.
    (* ASYNC_REG = "TRUE" *) logic [PTR_W-1:0] rd_s1;
    (* ASYNC_REG = "TRUE" *) logic [PTR_W-1:0] rd_s2;

    // A write is accepted only while not full; the RAM strobe is combinational.
    assign push          = wr_if.wr_en & ~wr_if.full;
    assign wr_if.wr_push = push;
    assign wr_if.wr_addr = wr_bin[DEPTH_SIZE-1:0];

    gray2bin #(
        .W    (PTR_W)
    ) u_rd_gray2bin (
        .gray (rd_s2),
        .bin  (rd_bin_sync)
    );

    // Next pointer and the status it implies against the synchronised read pointer.
    always_comb begin
        wr_bin_next  = wr_bin + {{DEPTH_SIZE{1'b0}}, push};
        wr_gray_next = PTR_W'(bin2gray(MAX_W'(wr_bin_next)));
        // Full when the write pointer is one lap ahead: top two Gray bits inverted.
        full_pattern = {~rd_s2[PTR_W-1:PTR_W-2], rd_s2[PTR_W-3:0]};
        full_next    = (wr_gray_next == full_pattern);
        level_next   = wr_bin_next - rd_bin_sync;
        af_next      = (level_next >= AF_LVL);
    end

    // Read-pointer synchroniser: plain flop chain, no logic in between.
    always_ff @(posedge wr_clk) begin
        // NOTE: reset is synchronous; wr_rst acts only at a wr_clk edge, and clears the sync flops too.
        if (wr_rst) begin
            rd_s1 <= '0;
            rd_s2 <= '0;
        end else begin
            // NOTE: non-blocking assignments so rd_s2 takes the pre-edge rd_s1, forming a true two-stage chain.
            rd_s1 <= rd_ptr_gray;
            rd_s2 <= rd_s1;
        end
    end

    // Write pointer in binary and registered Gray form for the read domain.
    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            wr_bin      <= '0;
            wr_ptr_gray <= '0;
        end else begin
            wr_bin      <= wr_bin_next;
            wr_ptr_gray <= wr_gray_next;
        end
    end

    // Registered producer status; overflow flags each write attempted while full.
    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            wr_if.full        <= 1'b0;
            wr_if.almost_full <= 1'b0;
            wr_if.wr_level    <= '0;
            wr_if.wr_overflow <= 1'b0;
        end else begin
            wr_if.full        <= full_next;
            wr_if.almost_full <= af_next;
            wr_if.wr_level    <= level_next;
            wr_if.wr_overflow <= wr_if.wr_en & wr_if.full;
        end
    end

endmodule
